// File: rtl/pin_verifier_multi.sv
// pin_verifier_multi: checks a submitted PIN against the master PIN, or the
// factory PIN until a master has been written, then scans the user slots at
// one slot per cycle. Each verification ends in one single-cycle pulse:
// res_master, res_user or res_fail.
// Optional build macro: PIN_LOCKOUT_EN adds the failed-attempt lockout.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   pin_valid           submission strobe; a rising edge starts one check
//   pin_digits          submitted PIN, digit 1 in the MSBs
//   master_pin          stored master PIN
//   user_pins, user_en  user slots (slot 0 in the LSBs) and their enables
//   master_written      pulse: a new master PIN has been stored
//   busy                verification in progress or result held
//   res_fail/user/master  result pulses
//   user_idx            index of the matching slot, valid with res_user
//   need_master_update  factory mode is active
//   locked, fail_cnt    lockout status and consecutive-failure count
module pin_verifier_multi #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int N_PINS      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] FACTORY_PIN = 16'h1234,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    localparam int PIN_W = DIGITS * DIGIT_W,
    localparam int IDX_W = (N_PINS > 1) ? $clog2(N_PINS) : 1,
    localparam int FC_W  = $clog2(MAX_FAILS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pin_valid,
    input  logic [PIN_W-1:0]        pin_digits,
    input  logic [PIN_W-1:0]        master_pin,
    input  logic [N_PINS*PIN_W-1:0] user_pins,
    input  logic [N_PINS-1:0]       user_en,
    input  logic                    master_written,
    output logic                    busy,
    output logic                    res_fail,
    output logic                    res_user,
    output logic                    res_master,
    output logic [IDX_W-1:0]        user_idx,
    output logic                    need_master_update,
    output logic                    locked,
    output logic [FC_W-1:0]         fail_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PINS - 1);

    typedef enum logic [2:0] {
        IDLE, CHK_MASTER, SCAN, DONE, LOCK
    } state_t;

    state_t            state_q, state_d;
    logic              prev_q, prev_d;
    logic [PIN_W-1:0]  cap_q, cap_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              res_fail_q, res_fail_d;
    logic              res_user_q, res_user_d;
    logic              res_master_q, res_master_d;
    logic [IDX_W-1:0]  user_idx_q, user_idx_d;
    logic              need_mu_q, need_mu_d;

    logic [PIN_W-1:0]  slot [N_PINS];
    logic [PIN_W-1:0]  master_ref;
    logic              slot_hit;

`ifdef PIN_LOCKOUT_EN
    localparam int TM_W = $clog2(LOCK_CYCLES + 1);
    logic [FC_W-1:0]   fc_q, fc_d, fc_inc;
    logic              locked_q, locked_d;
    logic [TM_W-1:0]   timer_q, timer_d;
`endif

    always_comb begin
        for (int i = 0; i < N_PINS; i++) begin
            slot[i] = user_pins[i*PIN_W +: PIN_W];
        end
    end

    // The factory PIN stands in for the master until one has been written.
    assign master_ref = need_mu_q ? FACTORY_PIN : master_pin;
    // A disabled slot still takes its cycle, so latency ignores user_en.
    assign slot_hit   = user_en[idx_q] && (slot[idx_q] == cap_q);

    always_comb begin
        state_d      = state_q;
        prev_d       = pin_valid;
        cap_d        = cap_q;
        idx_d        = idx_q;
        res_fail_d   = 1'b0;
        res_user_d   = 1'b0;
        res_master_d = 1'b0;
        user_idx_d   = user_idx_q;
        need_mu_d    = master_written ? 1'b0 : need_mu_q;
`ifdef PIN_LOCKOUT_EN
        fc_d         = fc_q;
        locked_d     = locked_q;
        timer_d      = timer_q;
        fc_inc       = (fc_q == FC_W'(MAX_FAILS)) ? fc_q : fc_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (pin_valid && !prev_q) begin
                    cap_d   = pin_digits;
                    state_d = CHK_MASTER;
                end
            end
            CHK_MASTER: begin
                if (cap_q == master_ref) begin
                    res_master_d = 1'b1;
`ifdef PIN_LOCKOUT_EN
                    fc_d         = '0;
`endif
                    state_d      = DONE;
                end else begin
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (slot_hit) begin
                    res_user_d = 1'b1;
                    user_idx_d = idx_q;
`ifdef PIN_LOCKOUT_EN
                    fc_d       = '0;
`endif
                    state_d    = DONE;
                end else if (idx_q == LAST_IDX) begin
                    res_fail_d = 1'b1;
                    state_d    = DONE;
`ifdef PIN_LOCKOUT_EN
                    fc_d       = fc_inc;
                    if (fc_inc == FC_W'(MAX_FAILS)) begin
                        locked_d = 1'b1;
                        timer_d  = TM_W'(LOCK_CYCLES);
                        state_d  = LOCK;
                    end
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (!pin_valid) begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
`ifdef PIN_LOCKOUT_EN
                if (timer_q <= TM_W'(1)) begin
                    locked_d = 1'b0;
                    fc_d     = '0;
                    state_d  = DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // prev_q resets high so a strobe held through reset cannot trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= 1'b1;
            cap_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            res_fail_q   <= 1'b0;
            res_user_q   <= 1'b0;
            res_master_q <= 1'b0;
            user_idx_q   <= '0;
            need_mu_q    <= 1'b1;
`ifdef PIN_LOCKOUT_EN
            fc_q         <= '0;
            locked_q     <= 1'b0;
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cap_q        <= cap_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            res_fail_q   <= res_fail_d;
            res_user_q   <= res_user_d;
            res_master_q <= res_master_d;
            user_idx_q   <= user_idx_d;
            need_mu_q    <= need_mu_d;
`ifdef PIN_LOCKOUT_EN
            fc_q         <= fc_d;
            locked_q     <= locked_d;
            timer_q      <= timer_d;
`endif
        end
    end

    assign busy               = busy_q;
    assign res_fail           = res_fail_q;
    assign res_user           = res_user_q;
    assign res_master         = res_master_q;
    assign user_idx           = user_idx_q;
    assign need_master_update = need_mu_q;
`ifdef PIN_LOCKOUT_EN
    assign locked             = locked_q;
    assign fail_cnt           = fc_q;
`else
    assign locked             = 1'b0;
    assign fail_cnt           = '0;
`endif

endmodule

// File: tb/tb_pin_verifier_multi.sv
// Scoreboard bench for pin_verifier_multi: directed submissions push the
// expected result and its cycle; a monitor pops on every result pulse.
module tb_pin_verifier_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        pin_valid;
    logic [15:0] pin_digits;
    logic [15:0] master_pin;
    logic [63:0] user_pins;
    logic [3:0]  user_en;
    logic        master_written;
    logic        busy, res_fail, res_user, res_master;
    logic [1:0]  user_idx;
    logic        need_master_update, locked;
    logic [1:0]  fail_cnt;

    pin_verifier_multi #(
        .DIGITS(4), .DIGIT_W(4), .N_PINS(4), .FACTORY_PIN(16'h1234),
        .MAX_FAILS(3), .LOCK_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .pin_valid(pin_valid),
        .pin_digits(pin_digits), .master_pin(master_pin),
        .user_pins(user_pins), .user_en(user_en),
        .master_written(master_written), .busy(busy),
        .res_fail(res_fail), .res_user(res_user),
        .res_master(res_master), .user_idx(user_idx),
        .need_master_update(need_master_update), .locked(locked),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } exp_t;

    localparam int K_FAIL = 0, K_USER = 1, K_MASTER = 2;

    exp_t exq[$];
    exp_t me;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_res_cyc = 0;
    int   exp_fc;
    int   guard;
    int   act_kind;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (res_fail || res_user || res_master)) begin
            chk("onehot", int'(res_fail) + int'(res_user) + int'(res_master), 1);
            if (exq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got f/u/m=%0b%0b%0b expected none (cycle %0d)",
                         res_fail, res_user, res_master, cyc);
            end else begin
                me = exq.pop_front();
                act_kind = res_master ? K_MASTER : (res_user ? K_USER : K_FAIL);
                chk("result_kind", act_kind, me.kind);
                chk("result_cycle", cyc, me.cyc);
                if (me.kind == K_USER) chk("user_idx", int'(user_idx), me.idx);
            end
        end
    end

    // A pulse is expected lat cycles after the capture edge E0.
    task automatic submit(input logic [15:0] pin, input int kind,
                          input int idx, input int lat, input int hold);
        exp_t e;
        @(negedge clk);
        pin_digits = pin;
        pin_valid  = 1'b1;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = cyc + 1 + lat;
        exq.push_back(e);
        last_res_cyc = e.cyc;
        repeat (lat + 2 + hold) @(negedge clk);
        if (hold > 0) chk("busy_while_held", int'(busy), 1);
        pin_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_res"}, int'(res_fail | res_user | res_master), 0);
        chk({tag, "_user_idx"}, int'(user_idx), 0);
        chk({tag, "_need_mu"}, int'(need_master_update), 1);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    endtask

    initial begin
        rst            = 1'b1;
        pin_valid      = 1'b0;
        pin_digits     = '0;
        master_pin     = 16'h9999;
        user_pins      = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        user_en        = 4'b1111;
        master_written = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        submit(16'h1234, K_MASTER, 0, 1, 0);
        chk("factory_need_mu", int'(need_master_update), 1);

        @(negedge clk) master_written = 1'b1;
        @(negedge clk) master_written = 1'b0;
        chk("need_mu_cleared", int'(need_master_update), 0);
        submit(16'h1234, K_FAIL, 0, 5, 0);
`ifdef PIN_LOCKOUT_EN
        exp_fc = 1;
`else
        exp_fc = 0;
`endif
        chk("fail_cnt_after_fail", int'(fail_cnt), exp_fc);

        submit(16'h3333, K_USER, 2, 4, 0);
        chk("fail_cnt_after_user", int'(fail_cnt), 0);

        user_en = 4'b1011;
        submit(16'h3333, K_FAIL, 0, 5, 0);

        user_en   = 4'b1111;
        user_pins = {16'h7777, 16'h3333, 16'h7777, 16'h1111};
        submit(16'h7777, K_USER, 1, 3, 0);

        user_pins = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        user_en   = 4'b1000;
        submit(16'h4444, K_USER, 3, 5, 0);

        user_en    = 4'b1111;
        master_pin = 16'h5555;
        user_pins  = {16'h4444, 16'h3333, 16'h2222, 16'h5555};
        submit(16'h5555, K_MASTER, 0, 1, 0);

        user_pins = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        submit(16'h2222, K_USER, 1, 3, 8);

        // Reset mid-scan with the strobe held high across release.
        @(negedge clk);
        pin_digits = 16'h0000;
        pin_valid  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midscan_rst");
        @(negedge clk) rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_trigger_after_rst", int'(busy), 0);
        pin_valid = 1'b0;
        repeat (2) @(negedge clk);

        submit(16'h0000, K_FAIL, 0, 5, 0);
        submit(16'h0000, K_FAIL, 0, 5, 0);
        submit(16'h0000, K_FAIL, 0, 5, 0);
`ifdef PIN_LOCKOUT_EN
        chk("locked_after_3", int'(locked), 1);
        chk("fail_cnt_sat", int'(fail_cnt), 3);
        @(negedge clk) begin
            pin_digits = 16'h1234;
            pin_valid  = 1'b1;
        end
        @(negedge clk) pin_valid = 1'b0;
        guard = 0;
        while (locked && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("lock_duration", cyc - last_res_cyc, 10);
        chk("fail_cnt_unlock", int'(fail_cnt), 0);
        repeat (2) @(negedge clk);
`else
        chk("locked_off", int'(locked), 0);
        chk("fail_cnt_off", int'(fail_cnt), 0);
`endif
        submit(16'h1234, K_MASTER, 0, 1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pin_verifier_multi.md
# pin_verifier_multi

Parametrised PIN verifier for the door-lock datapath: compares a submitted PIN against a master PIN and up to N_PINS user slots, scanning one slot per cycle, and reports fail / user-valid / master-valid as single-cycle pulses. It sits between the keypad PIN assembler and the lock control FSM. It adds factory-PIN first-boot handling, slot index reporting and a failed-attempt lockout.

## Interface

- DIGITS, 4, digits per PIN
- DIGIT_W, 4, bits per digit
- N_PINS, 4, number of user PIN slots (1..16)
- FACTORY_PIN, 16'h1234, factory master PIN, DIGITS*DIGIT_W bits, digit 1 in MSBs
- MAX_FAILS, 3, consecutive failures that trigger lockout (≥1)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (≥1)

Ports:

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pin_valid  in  1  submission strobe; a rising edge starts one verification
- pin_digits  in  DIGITS*DIGIT_W  submitted PIN, digit 1 in MSBs
- master_pin  in  DIGITS*DIGIT_W  stored master PIN
- user_pins  in  N_PINS*DIGITS*DIGIT_W  user slots, slot 0 in LSBs
- user_en  in  N_PINS  per-slot enable
- master_written  in  1  one-cycle pulse from setup logic: new master stored
- busy  out  1  verification in progress
- res_fail  out  1  pulse: no match
- res_user  out  1  pulse: user slot matched
- res_master  out  1  pulse: master (or factory) matched
- user_idx  out  clog2(N_PINS) (min 1)  matching slot, valid with res_user
- need_master_update  out  1  factory mode active
- locked  out  1  lockout active
- fail_cnt  out  clog2(MAX_FAILS+1)  consecutive failures

## Operation

- States: IDLE, CHK_MASTER, SCAN, DONE, LOCK.
- IDLE: a rising edge of pin_valid (prev-level register resets to 1) captures pin_digits, goes to CHK_MASTER, and sets busy.
- CHK_MASTER: compares against FACTORY_PIN if need_master_update=1, otherwise against master_pin.
  - Match: pulse res_master, clear fail_cnt, go to DONE.
  - No match: idx←0, go to SCAN.
- SCAN: compares the capture against slot idx only if user_en[idx]=1. A disabled slot still takes its cycle.
  - Match: pulse res_user, set user_idx←idx, clear fail_cnt, go to DONE.
  - idx==N_PINS-1 with no match: pulse res_fail, go to DONE, or to LOCK if the lockout threshold is reached.
  - Otherwise idx←idx+1.
- Priority: master over users; lowest slot index wins.
- DONE: stays until pin_valid=0, then goes to IDLE and drops busy. This prevents a held strobe from re-triggering.
- need_master_update: set by reset, cleared only by master_written. In factory mode, a master_pin match is not accepted; only FACTORY_PIN is.
- Reset mid-operation: all registers return to reset values and the capture is discarded. A pin_valid held high through reset does not trigger.

## Timing

- Reset values: busy=0, res_*=0, user_idx=0, need_master_update=1, locked=0, fail_cnt=0, state IDLE.
- Let E0 be the capture edge.
  - Master result is visible after E1.
  - Slot k result is visible after E(2+k).
  - Fail is visible after E(1+N_PINS).
  - Latency is fixed for a given outcome and independent of user_en.
- Result pulses are registered and last exactly one cycle; at most one is high at a time.
- Inputs other than pin_valid are sampled at compare time. Callers hold them stable while busy=1.
- pin_valid edges arriving while busy=1 or locked=1 are dropped, not queued.
- A master_written pulse coinciding with a CHK_MASTER compare takes effect from the next submission.

## Configuration

- PIN_LOCKOUT_EN defined:
  - Each fail increments fail_cnt, saturating at MAX_FAILS.
  - When the fail pulse brings fail_cnt to MAX_FAILS, the FSM enters LOCK with locked=1 and a timer loaded with LOCK_CYCLES.
  - After LOCK_CYCLES cycles, locked=0, fail_cnt=0, and the FSM returns to DONE (then IDLE once pin_valid=0).
- PIN_LOCKOUT_EN undefined: no counter or timer is instantiated; fail_cnt and locked are tied to 0, and fail always goes to DONE.

## Test plan

- Reset, then submit 1234 → res_master pulse after E1; need_master_update stays 1. Pulse master_written, submit 1234 with master_pin=9999 → res_fail after E5.
- need_master_update=0, slots {1111,2222,3333,4444}, all enabled, submit 3333 → res_user after E4 with user_idx=2, fail_cnt=0.
- user_en=4'b1011, submit 3333 → res_fail after E5; same PIN in slots 1 and 3 → user_idx=1.
- master_pin=5555, slot 0=5555, submit 5555 → res_master only, after E1.
- PIN_LOCKOUT_EN defined, MAX_FAILS=3, LOCK_CYCLES=10: three wrong PINs → locked=1 after the third fail; a submission during lock is ignored; locked=0 and fail_cnt=0 after 10 cycles.
- Hold pin_valid high across a result → exactly one pulse. Assert rst during SCAN → all outputs at reset values; no result pulse appears after release.
